// File: rtl/mips_boot_loader_if.sv
// Byte-stream input handshake and memory byte-write bus of the MIPS boot loader.
// The master is the host/bench side that feeds bytes and observes the write bus.
// The slave is the loader itself.
interface mips_boot_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_boot_loader.sv
// Framed byte-stream loader for the single-cycle MIPS core.
// Load frames write payload bytes into instruction or data memory through
// their byte write ports. Control bytes release (0x03) or halt (0x04) the core.
// Every output is registered. A write strobe appears exactly one cycle after
// its payload byte is accepted.
module mips_boot_loader #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_boot_loader_if.slave bus,
    output logic              cpu_run,
    output logic              load_done,
    output logic              err
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_LEN_HI  = 3'd3,
        S_LEN_LO  = 3'd4,
        S_DATA    = 3'd5,
        S_RUN     = 3'd6
    } state_e;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
    localparam logic [7:0] CMD_START     = 8'h03;
    localparam logic [7:0] CMD_HALT      = 8'h04;

    state_e            state_q;
    logic              tgt_dmem_q;   // 1: payload goes to dmem, 0: to imem
    logic [7:0]        hdr_hi_q;     // high byte of the address or length field
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              in_ready_q;
    logic              imem_we_q;
    logic              dmem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cpu_run_q;
    logic              load_done_q;
    logic              err_q;

    logic              accept_s;
    logic [15:0]       hdr_word_s;   // big-endian header field being completed
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  rem_d;

    // Byte acceptance, header word assembly and the per-byte increments.
    always_comb begin
        accept_s   = bus.in_valid & in_ready_q;
        hdr_word_s = {hdr_hi_q, bus.in_data};
        addr_d     = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        rem_d      = rem_q - LEN_W'(1);
    end

    // Frame parser FSM; strobes, load_done and in_ready are rebuilt every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tgt_dmem_q  <= 1'b0;
            hdr_hi_q    <= 8'h00;
            addr_q      <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cpu_run_q   <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            load_done_q <= 1'b0;
            in_ready_q  <= 1'b1;
            if (accept_s) begin
                case (state_q)
                    S_IDLE: begin
                        case (bus.in_data)
                            CMD_LOAD_IMEM: begin
                                tgt_dmem_q <= 1'b0;
                                state_q    <= S_ADDR_HI;
                            end
                            CMD_LOAD_DMEM: begin
                                tgt_dmem_q <= 1'b1;
                                state_q    <= S_ADDR_HI;
                            end
                            CMD_START: begin
                                cpu_run_q <= 1'b1;
                                state_q   <= S_RUN;
                            end
                            default: err_q <= 1'b1;   // illegal byte is consumed
                        endcase
                    end
                    S_ADDR_HI: begin
                        hdr_hi_q <= bus.in_data;
                        state_q  <= S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        addr_q  <= hdr_word_s[ADDR_W-1:0];   // upper address bits dropped
                        state_q <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        hdr_hi_q <= bus.in_data;
                        state_q  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        if (hdr_word_s == 16'h0000) begin
                            // Empty frame: finish immediately without writes.
                            load_done_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            rem_q   <= hdr_word_s;
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        imem_we_q   <= ~tgt_dmem_q;
                        dmem_we_q   <= tgt_dmem_q;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= bus.in_data;
                        addr_q      <= addr_d;
                        rem_q       <= rem_d;
                        if (rem_q == LEN_W'(1)) begin
                            // Final byte: done pulse lines up with the last strobe.
                            load_done_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_RUN: begin
                        if (bus.in_data == CMD_HALT) begin
                            cpu_run_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            state_q <= S_RUN;   // anything else is discarded
                        end
                    end
                    default: begin
                        cpu_run_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.imem_we   = imem_we_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_run       = cpu_run_q;
    assign load_done     = load_done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed self-checking bench for mips_boot_loader.
// Inputs change 1 time unit after a rising edge, and outputs are sampled there too.
module tb_mips_boot_loader;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_run;
    logic load_done;
    logic err;
    int   errors = 0;
    int   checks = 0;

    mips_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one edge; the loader must be ready for it.
    task automatic send(input logic [7:0] b);
        chk("in_ready before byte", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Byte that must not produce any write or done pulse.
    task automatic nw(input string tag, input logic [7:0] b);
        send(b);
        chk({tag, " imem_we"},   {31'd0, bus.imem_we}, 32'd0);
        chk({tag, " dmem_we"},   {31'd0, bus.dmem_we}, 32'd0);
        chk({tag, " load_done"}, {31'd0, load_done},   32'd0);
    endtask

    // Payload byte that must produce a strobe in the following cycle.
    task automatic wr(input string tag, input logic [7:0] b, input logic to_dmem,
                      input logic [9:0] addr, input logic done);
        send(b);
        chk({tag, " imem_we"},   {31'd0, bus.imem_we},   {31'd0, ~to_dmem});
        chk({tag, " dmem_we"},   {31'd0, bus.dmem_we},   {31'd0, to_dmem});
        chk({tag, " mem_addr"},  {22'd0, bus.mem_addr},  {22'd0, addr});
        chk({tag, " mem_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, b});
        chk({tag, " load_done"}, {31'd0, load_done},     {31'd0, done});
        chk({tag, " in_ready"},  {31'd0, bus.in_ready},  {31'd0, ~done});
    endtask

    // Idle cycles: no strobes, no done, loader ready.
    task automatic idle(input string tag, input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk({tag, " idle imem_we"},   {31'd0, bus.imem_we},  32'd0);
            chk({tag, " idle dmem_we"},   {31'd0, bus.dmem_we},  32'd0);
            chk({tag, " idle load_done"}, {31'd0, load_done},    32'd0);
            chk({tag, " idle in_ready"},  {31'd0, bus.in_ready}, 32'd1);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_ready"},  {31'd0, bus.in_ready},  32'd0);
        chk({tag, " imem_we"},   {31'd0, bus.imem_we},   32'd0);
        chk({tag, " dmem_we"},   {31'd0, bus.dmem_we},   32'd0);
        chk({tag, " mem_addr"},  {22'd0, bus.mem_addr},  32'd0);
        chk({tag, " mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
        chk({tag, " cpu_run"},   {31'd0, cpu_run},       32'd0);
        chk({tag, " load_done"}, {31'd0, load_done},     32'd0);
        chk({tag, " err"},       {31'd0, err},           32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state, then in_ready rises on the first edge after release.
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("in_ready after first edge", {31'd0, bus.in_ready}, 32'd1);

        // One word to imem, back-to-back.
        nw("t1 cmd", 8'h01); nw("t1 ah", 8'h00); nw("t1 al", 8'h00);
        nw("t1 lh", 8'h00);  nw("t1 ll", 8'h04);
        wr("t1 b0", 8'h8C, 1'b0, 10'h000, 1'b0);
        wr("t1 b1", 8'h08, 1'b0, 10'h001, 1'b0);
        wr("t1 b2", 8'h00, 1'b0, 10'h002, 1'b0);
        wr("t1 b3", 8'h00, 1'b0, 10'h003, 1'b1);
        chk("t1 err", {31'd0, err}, 32'd0);
        idle("t1", 1);
        chk("t1 addr hold",  {22'd0, bus.mem_addr},  32'h003);
        chk("t1 wdata hold", {24'd0, bus.mem_wdata}, 32'h000);

        // dmem load with two idle cycles between every byte.
        nw("t2 cmd", 8'h02); idle("t2", 2);
        nw("t2 ah", 8'h00);  idle("t2", 2);
        nw("t2 al", 8'h04);  idle("t2", 2);
        nw("t2 lh", 8'h00);  idle("t2", 2);
        nw("t2 ll", 8'h04);  idle("t2", 2);
        wr("t2 b0", 8'h00, 1'b1, 10'h004, 1'b0); idle("t2", 2);
        wr("t2 b1", 8'h00, 1'b1, 10'h005, 1'b0); idle("t2", 2);
        wr("t2 b2", 8'h00, 1'b1, 10'h006, 1'b0); idle("t2", 2);
        wr("t2 b3", 8'h05, 1'b1, 10'h007, 1'b1);
        idle("t2", 1);

        // Address wrap-around at the top of the 10-bit space.
        nw("t3 cmd", 8'h01); nw("t3 ah", 8'h03); nw("t3 al", 8'hFE);
        nw("t3 lh", 8'h00);  nw("t3 ll", 8'h04);
        wr("t3 b0", 8'hAA, 1'b0, 10'h3FE, 1'b0);
        wr("t3 b1", 8'hBB, 1'b0, 10'h3FF, 1'b0);
        wr("t3 b2", 8'hCC, 1'b0, 10'h000, 1'b0);
        wr("t3 b3", 8'hDD, 1'b0, 10'h001, 1'b1);
        idle("t3", 1);

        // Zero-length frame: done pulse right after LEN_LO, no strobes.
        nw("t4 cmd", 8'h01); nw("t4 ah", 8'h00); nw("t4 al", 8'h10);
        nw("t4 lh", 8'h00);
        send(8'h00);
        chk("t4 load_done", {31'd0, load_done},    32'd1);
        chk("t4 in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("t4 imem_we",   {31'd0, bus.imem_we},  32'd0);
        chk("t4 dmem_we",   {31'd0, bus.dmem_we},  32'd0);
        idle("t4", 1);
        chk("t4 addr hold", {22'd0, bus.mem_addr}, 32'h001);

        // Illegal command sets sticky err; a following frame still loads.
        nw("t5 bad", 8'h7F);
        chk("t5 err set", {31'd0, err}, 32'd1);
        nw("t5 cmd", 8'h02); nw("t5 ah", 8'h00); nw("t5 al", 8'h20);
        nw("t5 lh", 8'h00);  nw("t5 ll", 8'h01);
        wr("t5 b0", 8'h55, 1'b1, 10'h020, 1'b1);
        idle("t5", 1);
        chk("t5 err sticky", {31'd0, err}, 32'd1);

        // Run / halt: bytes in RUN are discarded.
        send(8'h03);
        chk("t6 cpu_run on", {31'd0, cpu_run}, 32'd1);
        nw("t6 run b0", 8'h01); nw("t6 run b1", 8'h00); nw("t6 run b2", 8'h00);
        chk("t6 cpu_run held", {31'd0, cpu_run}, 32'd1);
        chk("t6 err unchanged", {31'd0, err}, 32'd1);
        send(8'h04);
        chk("t6 cpu_run off", {31'd0, cpu_run}, 32'd0);
        nw("t6 cmd", 8'h01); nw("t6 ah", 8'h00); nw("t6 al", 8'h08);
        nw("t6 lh", 8'h00);  nw("t6 ll", 8'h01);
        wr("t6 b0", 8'h77, 1'b0, 10'h008, 1'b1);
        idle("t6", 1);

        // Asynchronous reset in the middle of a payload.
        nw("t7 cmd", 8'h02); nw("t7 ah", 8'h00); nw("t7 al", 8'h40);
        nw("t7 lh", 8'h00);  nw("t7 ll", 8'h04);
        wr("t7 b0", 8'h11, 1'b1, 10'h040, 1'b0);
        wr("t7 b1", 8'h22, 1'b1, 10'h041, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t7 async");
        @(posedge clk);
        #1;
        chk("t7 in_ready in reset", {31'd0, bus.in_ready}, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t7 in_ready after release", {31'd0, bus.in_ready}, 32'd1);
        nw("t7 idle cmd", 8'h33);
        chk("t7 err from 33", {31'd0, err}, 32'd1);
        nw("t7 cmd", 8'h01); nw("t7 ah", 8'h00); nw("t7 al", 8'h00);
        nw("t7 lh", 8'h00);  nw("t7 ll", 8'h01);
        wr("t7 b2", 8'h99, 1'b0, 10'h000, 1'b1);
        idle("t7", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
